// File: rtl/neuron_share_arbiter.sv
// neuron_share_arbiter: round-robin sharing of one pipelined neuron between N_REQ requesters,
// with a latency-matched tag line steering each activation back to its issuer.
module neuron_share_arbiter #(
   parameter int N_REQ       = 4,
   parameter int N_INPUTS    = 37,
   parameter int NEU_LATENCY = 6,
   parameter int DATA_W      = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [N_REQ-1:0]                 req_valid,
   output logic [N_REQ-1:0]                 req_ready,
   input  logic [N_REQ*N_INPUTS*DATA_W-1:0] req_data,
   output logic [N_INPUTS*DATA_W-1:0]       neu_in,
   input  logic [DATA_W-1:0]                neu_out,
   output logic [N_REQ-1:0]                 res_valid,
   output logic [DATA_W-1:0]                res_data,
   output logic                             busy
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int VW = N_INPUTS * DATA_W;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    gnt_id;
   logic [PW-1:0]    idx;
   logic [PW:0]      sum;
   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] res_hot;
   logic             found;
   logic             xfer;
   logic [NEU_LATENCY:0] tag_v;
   logic [PW-1:0]        tag_id [NEU_LATENCY+1];
   // first valid requester at or after the pointer, wrapping modulo N_REQ
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         idx = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ)) : sum[PW-1:0];
         if (!found && req_valid[idx]) begin
            found       = 1'b1;
            gnt[idx]    = 1'b1;
            gnt_id      = idx;
         end
      end
      if (rst) gnt = '0;
   end
   assign req_ready = gnt;
   assign xfer      = |gnt;
   always_comb begin
      res_hot                      = '0;
      res_hot[tag_id[NEU_LATENCY]] = 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         neu_in    <= '0;
         tag_v     <= '0;
         tag_id    <= '{default: '0};
         res_valid <= '0;
         res_data  <= '0;
      end else begin
         if (xfer) begin
            ptr    <= (int'(gnt_id) == N_REQ-1) ? '0 : gnt_id + 1'b1;
            neu_in <= req_data[int'(gnt_id)*VW +: VW];
         end
         tag_v     <= {tag_v[NEU_LATENCY-1:0], xfer};
         tag_id[0] <= gnt_id;
         for (int s = 1; s <= NEU_LATENCY; s++) tag_id[s] <= tag_id[s-1];
         res_valid <= tag_v[NEU_LATENCY] ? res_hot : '0;
         res_data  <= tag_v[NEU_LATENCY] ? neu_out : res_data;
      end
   end
   assign busy = (|tag_v) | (|res_valid);
endmodule

// File: tb/tb_neuron_share_arbiter.sv
// tb_neuron_share_arbiter: directed checks of arbitration, result routing, latency, busy and reset.
module tb_neuron_share_arbiter;
   localparam int N = 4, NI = 37, L = 6, W = 32;
   logic clk = 1'b0;
   logic rst;
   logic [N-1:0] req_valid, req_ready, res_valid;
   logic [N*NI*W-1:0] req_data;
   logic [NI*W-1:0] neu_in;
   logic [W-1:0] neu_out, res_data;
   logic busy;
   int passed = 0, total = 0, cyc = 0;
   int n1, n3, alt_ok;
   typedef struct {int c; logic [N-1:0] v; logic [W-1:0] d;} ev_t;
   ev_t glog[$], rlog[$];
   logic [W-1:0] pipe [L];

   always #5 clk = ~clk;

   neuron_share_arbiter #(.N_REQ(N), .N_INPUTS(NI), .NEU_LATENCY(L), .DATA_W(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .neu_in(neu_in), .neu_out(neu_out), .res_valid(res_valid), .res_data(res_data), .busy(busy));

   // stand-in neuron: 8-bit sum of element low bytes, L-stage pipeline
   function automatic logic [W-1:0] neuron_f(input logic [NI*W-1:0] v);
      logic [7:0] s = 8'd0;
      for (int j = 0; j < NI; j++) s += v[j*W +: 8];
      return {24'b0, s};
   endfunction
   always @(posedge clk) begin
      pipe[0] <= neuron_f(neu_in);
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
   end
   assign neu_out = pipe[L-1];

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (|(req_valid & req_ready)) glog.push_back('{cyc, req_valid & req_ready, '0});
   always @(negedge clk) if (|res_valid) rlog.push_back('{cyc, res_valid, res_data});

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_vec(input int i, input int val);
      for (int j = 0; j < NI; j++) req_data[(i*NI+j)*W +: W] = W'(val);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      glog.delete();
      rlog.delete();
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '1;
      req_data = '0;
      idle(2);
      chk("rst_ready", 64'(req_ready), 0);
      chk("rst_res_valid", 64'(res_valid), 0);
      chk("rst_res_data", 64'(res_data), 0);
      chk("rst_neu_in", 64'(|neu_in), 0);
      chk("rst_busy", 64'(busy), 0);
      // single vector from requester 2
      rst = 1'b0;
      req_valid = 4'b0100;
      set_vec(2, 1);
      #1 chk("t1_ready", 64'(req_ready), 64'b0100);
      @(negedge clk);
      req_valid = '0;
      chk("t1_neu_in_e0", 64'(neu_in[W-1:0]), 1);
      chk("t1_neu_in_e36", 64'(neu_in[NI*W-1 -: W]), 1);
      chk("t1_busy_start", 64'(busy), 1);
      idle(6);
      chk("t1_busy_mid", 64'(busy), 1);
      chk("t1_no_early", 64'(res_valid), 0);
      idle(1);
      chk("t1_res_valid", 64'(res_valid), 64'b0100);
      chk("t1_res_data", 64'(res_data), 37);
      chk("t1_busy_pulse", 64'(busy), 1);
      idle(1);
      chk("t1_pulse_end", 64'(res_valid), 0);
      chk("t1_data_hold", 64'(res_data), 37);
      chk("t1_busy_end", 64'(busy), 0);
      chk("t1_grants", 64'(glog.size()), 1);
      chk("t1_results", 64'(rlog.size()), 1);
      if (rlog.size() == 1 && glog.size() == 1) chk("t1_latency", 64'(rlog[0].c - glog[0].c), 8);
      // all four contend from pointer 0
      do_reset();
      for (int i = 0; i < N; i++) set_vec(i, i + 1);
      req_valid = '1;
      idle(4);
      req_valid = '0;
      idle(12);
      chk("t2_grants", 64'(glog.size()), 4);
      chk("t2_results", 64'(rlog.size()), 4);
      if (glog.size() == 4 && rlog.size() == 4)
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_gnt%0d", k), 64'(glog[k].v), 64'(1 << k));
            chk($sformatf("t2_gcyc%0d", k), 64'(glog[k].c - glog[0].c), 64'(k));
            chk($sformatf("t2_rv%0d", k), 64'(rlog[k].v), 64'(1 << k));
            chk($sformatf("t2_rd%0d", k), 64'(rlog[k].d), 64'(37 * (k + 1)));
            chk($sformatf("t2_lat%0d", k), 64'(rlog[k].c - glog[k].c), 8);
         end
      // fairness 1 vs 3 with pointer wrap
      glog.delete();
      rlog.delete();
      set_vec(1, 5);
      set_vec(3, 7);
      req_valid = 4'b1010;
      idle(40);
      req_valid = '0;
      idle(12);
      n1 = 0;
      n3 = 0;
      alt_ok = 1;
      foreach (glog[k]) begin
         if (glog[k].v == 4'b0010) n1++;
         if (glog[k].v == 4'b1000) n3++;
         if (glog[k].v != ((k % 2 == 0) ? 4'b0010 : 4'b1000) || glog[k].c != glog[0].c + k) alt_ok = 0;
      end
      chk("t3_n1", 64'(n1), 20);
      chk("t3_n3", 64'(n3), 20);
      chk("t3_alternate", 64'(alt_ok), 1);
      chk("t3_results", 64'(rlog.size()), 40);
      // back-to-back single requester
      glog.delete();
      rlog.delete();
      req_valid = 4'b0001;
      for (int k = 0; k < 10; k++) begin
         set_vec(0, k + 10);
         @(negedge clk);
      end
      req_valid = '0;
      idle(12);
      chk("t4_grants", 64'(glog.size()), 10);
      chk("t4_results", 64'(rlog.size()), 10);
      if (rlog.size() == 10)
         for (int k = 0; k < 10; k++) begin
            chk($sformatf("t4_rd%0d", k), 64'(rlog[k].d), 64'((37 * (k + 10)) % 256));
            chk($sformatf("t4_rc%0d", k), 64'(rlog[k].c - rlog[0].c), 64'(k));
         end
      // reset mid-flight
      glog.delete();
      rlog.delete();
      req_valid = 4'b0111;
      idle(3);
      req_valid = '0;
      idle(2);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("t5_busy_after_rst", 64'(busy), 0);
      chk("t5_res_data_rst", 64'(res_data), 0);
      idle(12);
      chk("t5_grants", 64'(glog.size()), 3);
      chk("t5_no_results", 64'(rlog.size()), 0);
      glog.delete();
      set_vec(2, 3);
      req_valid = 4'b0100;
      #1 chk("t5_ready", 64'(req_ready), 64'b0100);
      @(negedge clk);
      req_valid = '0;
      idle(10);
      chk("t5_results", 64'(rlog.size()), 1);
      if (rlog.size() == 1 && glog.size() == 1) begin
         chk("t5_latency", 64'(rlog[0].c - glog[0].c), 8);
         chk("t5_rd", 64'(rlog[0].d), 111);
      end
      // withdrawn request
      do_reset();
      set_vec(0, 2);
      req_valid = 4'b0011;
      #1 chk("t6_ready", 64'(req_ready), 64'b0001);
      @(negedge clk);
      req_valid = 4'b1111;
      #1 chk("t6_ptr1", 64'(req_ready), 64'b0010);
      req_valid = '0;
      #1 chk("t6_no_ready", 64'(req_ready), 0);
      idle(12);
      chk("t6_grants", 64'(glog.size()), 1);
      chk("t6_results", 64'(rlog.size()), 1);
      if (glog.size() == 1) chk("t6_gnt", 64'(glog[0].v), 64'b0001);
      if (rlog.size() == 1) begin
         chk("t6_rv", 64'(rlog[0].v), 64'b0001);
         chk("t6_rd", 64'(rlog[0].d), 74);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/neuron_share_arbiter.md
Name: neuron_share_arbiter

Overview:
- Shares one fully pipelined 37-input neuron instance (MAC tree, bias, saturation, sigmoid ROM) between N_REQ independent requesters.
- Round-robin arbiter accepts at most one input vector per cycle and registers it onto the neuron inputs.
- A tag delay line matched to the neuron latency routes each activation back to the requester that issued it.
- Sits between layer-level feeders and the shared neuron; the neuron itself cannot stall.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- N_INPUTS, 37, inputs per vector (excludes bias)
- NEU_LATENCY, 6, cycles from a vector being driven on neu_in to its result being valid on neu_out
- DATA_W, 32, width of each input element and of the result

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  requester i has a vector ready
- req_ready  out  N_REQ  one-hot grant; at most one bit set per cycle
- req_data  in  N_REQ*N_INPUTS*DATA_W  flattened vectors; requester i at slice i, element j at sub-slice j
- neu_in  out  N_INPUTS*DATA_W  registered vector driven to the shared neuron
- neu_out  in  DATA_W  neuron activation result (0..255, zero-extended)
- res_valid  out  N_REQ  one-hot, 1-cycle pulse; the result belongs to requester i
- res_data  out  DATA_W  result value, qualified by res_valid
- busy  out  1  high while any accepted vector has no result yet

Behaviour:
- Reset (rst high at an edge) sets:
  - req_ready=0, res_valid=0, res_data=0, neu_in=0, busy=0.
  - Round-robin pointer = 0.
  - Tag delay line cleared to all-invalid.
- The first cycle after reset already arbitrates normally.

Arbitration:
- req_ready is combinational from req_valid and the registered pointer.
- Search starts at the pointer index and wraps modulo N_REQ. The first asserted req_valid gets req_ready.
- Transfer when req_valid[i] & req_ready[i] at a posedge.
- On a transfer to i, the pointer becomes (i+1) mod N_REQ. With no transfer, the pointer is unchanged.
- req_ready is never asserted for a requester whose req_valid is low.
- A requester holds req_data stable while req_valid is high and not yet accepted. It may deassert req_valid at any time before acceptance.

Datapath:
- On a transfer at edge a, neu_in is loaded with req_data slice i. neu_in holds its value until the next transfer; it is not cleared on idle cycles.
- At the same edge, the tag delay line stage 0 gets {valid=1, id=i}. With no transfer, stage 0 gets valid=0.
- The tag delay line is NEU_LATENCY+1 stages and shifts every cycle unconditionally.
- When the last stage is valid with id k:
  - res_valid[k]=1 and res_data=neu_out for exactly one cycle.
  - Otherwise res_valid=0 and res_data holds its last value.
- Latency: acceptance at edge a gives a result in the cycle after edge a+NEU_LATENCY+1, i.e. NEU_LATENCY+2 cycles. This is independent of load.
- Throughput is one vector per cycle, sustained. Results return in acceptance order.
- No backpressure on results: consumers must take res_valid pulses as they arrive.

busy:
- busy = OR of all tag delay line valid bits. A result-pending register is included in this OR.
- busy is high from the cycle after the first acceptance until the cycle after the last res_valid pulse.

Boundary conditions:
- All requesters valid at once: exactly one grant per cycle, in rotation from the pointer.
- Pointer wrap: a grant to N_REQ-1 sets the pointer to 0.
- A single requester continuously valid: granted every cycle (no forced bubble).
- rst mid-operation:
  - All in-flight tags are dropped, so no res_valid pulses follow for vectors accepted before reset.
  - Stale neuron pipeline contents are ignored.
- rst and req_valid in the same cycle: no transfer; req_ready is 0 during reset.

Test Plan:
- Single vector, requester 2: after reset, req_valid[2] with all 37 elements = 1 → transfer at edge 0; res_valid=4'b0100 exactly NEU_LATENCY+2 cycles later; res_data equals the neuron's output for that vector; busy high for that span.
- Contention: all four req_valid held high from reset for 4 cycles, pointer 0 → grants 0,1,2,3 on consecutive edges; res_valid pulses 0001, 0010, 0100, 1000 on consecutive cycles starting at NEU_LATENCY+2.
- Fairness and wrap: requesters 1 and 3 continuously valid → grants alternate 1,3,1,3; after a grant to 3 the pointer wraps to 0, so 1 wins next; 40 cycles yield 20 grants each.
- Back-to-back single requester: req_valid[0] high for 10 cycles with distinct vectors → 10 consecutive grants; 10 consecutive res_valid[0] pulses with results in submission order.
- Reset mid-flight: 3 vectors accepted, rst asserted 2 cycles later for 1 cycle → no res_valid pulses ever; busy=0 after reset; the next request completes with normal latency.
- Withdrawn request: req_valid[1] is high one cycle while requester 0 is granted, then dropped → no grant to 1, no result for 1; the pointer is 1 after the grant to 0.
